// File: rtl/os_result_drain_pkg.sv
// Shared types and defaults for the output-stationary result drain.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
// Contents: drain_state_e FSM encoding, default array geometry, row_t packed row.
package os_pkg;

  localparam int ARRAY_SIZE_DEF = 4;
  localparam int ACC_WIDTH_DEF  = 24;
  localparam int SAT_WIDTH_DEF  = 16;
  localparam int ROW_WIDTH_DEF  = ACC_WIDTH_DEF * ARRAY_SIZE_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    EMIT    = 2'd3
  } drain_state_e;

  typedef logic [ROW_WIDTH_DEF-1:0] row_t;

  // Row-index width; a degenerate 1-row array still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/os_result_drain_if.sv
// Row stream from the drain stage to the result memory writer.
// Latency: n/a (signal bundle only).
// Backpressure: valid/ready; master holds data stable while out_ready is low.
// Modports: master drives out_valid/out_data/out_row_idx/out_last, slave drives out_ready.
interface os_result_drain_if #(
  parameter int ARRAY_SIZE = os_pkg::ARRAY_SIZE_DEF,
  parameter int ACC_WIDTH  = os_pkg::ACC_WIDTH_DEF
);
  localparam int ROW_WIDTH = ACC_WIDTH * ARRAY_SIZE;
  localparam int IDX_W     = os_pkg::idx_width(ARRAY_SIZE);

  logic                 out_valid;
  logic                 out_ready;
  logic [ROW_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]     out_row_idx;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_row_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row_idx,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/os_result_drain_lane_sat.sv
// Signed clamp of one accumulator lane into the SAT_WIDTH range, sign-extended back.
// Latency: combinational.
// Backpressure: none.
// Ports: din (raw lane), dout (clamped lane), hit (high when din was out of range).
module os_lane_sat #(
  parameter int ACC_WIDTH = os_pkg::ACC_WIDTH_DEF,
  parameter int SAT_WIDTH = os_pkg::SAT_WIDTH_DEF
) (
  input  logic [ACC_WIDTH-1:0] din,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 hit
);
  localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'((64'sd1 <<< (SAT_WIDTH - 1)) - 64'sd1);
  // Two's complement: ~max == -max-1 == -2^(SAT_WIDTH-1).
  localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;

  always_comb begin
    dout = din;
    hit  = 1'b0;
    if ($signed(din) > MAX_V) begin
      dout = MAX_V;
      hit  = 1'b1;
    end else if ($signed(din) < MIN_V) begin
      dout = MIN_V;
      hit  = 1'b1;
    end
  end
endmodule

// File: rtl/os_result_drain.sv
// Drains the PE array: shifts shadow results out, snapshots the rows, then streams one row per handshake.
// Latency: start sampled at T -> shift_en T+1..T+N -> capture T+N+1 -> first out_valid T+N+2.
// Backpressure: out_ready low holds the current row stable; a start while busy is dropped and flagged.
// Ports: clk, rst_n, drain_start, result_row[N], shift_en, array_free, busy, drop_err, out (row stream master).
// Build option: define OS_DRAIN_SAT_EN to clamp lanes to SAT_WIDTH at capture and add the sticky sat_hit output.
module os_result_drain
  import os_pkg::*;
#(
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
`ifdef OS_DRAIN_SAT_EN
  ,
  parameter int SAT_WIDTH  = SAT_WIDTH_DEF
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic drain_start,
  input  logic [ACC_WIDTH*ARRAY_SIZE-1:0] result_row [ARRAY_SIZE-1:0],
  output logic shift_en,
  output logic array_free,
  output logic busy,
  output logic drop_err,
`ifdef OS_DRAIN_SAT_EN
  output logic sat_hit,
`endif
  os_result_drain_if.master out
);
  localparam int ROW_WIDTH = ACC_WIDTH * ARRAY_SIZE;
  localparam int IDX_W     = idx_width(ARRAY_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_SIZE - 1);

  drain_state_e         state;
  logic [IDX_W-1:0]     sft_cnt;
  logic [IDX_W-1:0]     row_cnt;
  logic [IDX_W-1:0]     nxt_row;
  logic [ROW_WIDTH-1:0] buffer  [ARRAY_SIZE];
  logic [ROW_WIDTH-1:0] cap_row [ARRAY_SIZE];

  assign nxt_row = row_cnt + 1'b1;

`ifdef OS_DRAIN_SAT_EN
  logic [ARRAY_SIZE*ARRAY_SIZE-1:0] lane_hit;

  // Column 0 sits in the most-significant lane of each row.
  for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_lane
      os_lane_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .SAT_WIDTH (SAT_WIDTH)
      ) u_sat (
        .din  (result_row[r][ROW_WIDTH-1-c*ACC_WIDTH -: ACC_WIDTH]),
        .dout (cap_row[r][ROW_WIDTH-1-c*ACC_WIDTH -: ACC_WIDTH]),
        .hit  (lane_hit[r*ARRAY_SIZE+c])
      );
    end
  end
`else
  for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
    assign cap_row[r] = result_row[r];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      sft_cnt         <= '0;
      row_cnt         <= '0;
      shift_en        <= 1'b0;
      array_free      <= 1'b1;
      busy            <= 1'b0;
      drop_err        <= 1'b0;
      out.out_valid   <= 1'b0;
      out.out_data    <= '0;
      out.out_row_idx <= '0;
      out.out_last    <= 1'b0;
      for (int i = 0; i < ARRAY_SIZE; i++) buffer[i] <= '0;
`ifdef OS_DRAIN_SAT_EN
      sat_hit         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (drain_start) begin
            state      <= SHIFT;
            sft_cnt    <= '0;
            shift_en   <= 1'b1;
            array_free <= 1'b0;
            busy       <= 1'b1;
          end
        end

        SHIFT: begin
          if (sft_cnt == LAST_IDX) begin
            state    <= CAPTURE;
            shift_en <= 1'b0;
            sft_cnt  <= '0;
          end else begin
            sft_cnt  <= sft_cnt + 1'b1;
          end
        end

        // Row 0 is loaded straight from the capture path so the first
        // beat does not wait for the buffer write.
        CAPTURE: begin
          for (int i = 0; i < ARRAY_SIZE; i++) buffer[i] <= cap_row[i];
          row_cnt         <= '0;
          out.out_valid   <= 1'b1;
          out.out_data    <= cap_row[0];
          out.out_row_idx <= '0;
          out.out_last    <= (ARRAY_SIZE == 1);
          array_free      <= 1'b1;
          state           <= EMIT;
`ifdef OS_DRAIN_SAT_EN
          if (|lane_hit) sat_hit <= 1'b1;
`endif
        end

        EMIT: begin
          if (out.out_ready) begin
            if (row_cnt == LAST_IDX) begin
              state         <= IDLE;
              busy          <= 1'b0;
              out.out_valid <= 1'b0;
              out.out_last  <= 1'b0;
              row_cnt       <= '0;
            end else begin
              row_cnt         <= nxt_row;
              out.out_data    <= buffer[nxt_row];
              out.out_row_idx <= nxt_row;
              out.out_last    <= (nxt_row == LAST_IDX);
            end
          end
        end

        default: state <= IDLE;
      endcase

      // Any start outside IDLE is lost, including one coinciding with the
      // final transfer of the previous tile.
      if (drain_start && (state != IDLE)) drop_err <= 1'b1;
    end
  end
endmodule
